riscv_stream_mmio: RTL and testbench
====================================

# riscv_stream_mmio

Parametrised memory-mapped stream I/O slave for the picorv32 native memory bus. It replaces the fixed five-port stream plumbing and the ad-hoc print decode with NUM_CH channels. Each channel has an independent TX FIFO (CPU to consumer) and RX FIFO (producer to CPU), with blocking and non-blocking access, status, and flush. It sits beside the instruction/data BRAM in the RISC-V page, and its stream ports face the neighbouring pages' valid/ready links.

## Interface
Parameters:
- NUM_CH, 5: number of stream channels, 1..16.
- DATA_WIDTH, 32: stream word width, 1..32. Narrower words are zero-extended on read and truncated on write.
- FIFO_DEPTH, 4: entries per FIFO; power of two, 2..128.
- BASE_ADDR, 32'h2000_0000: base of the 4 KiB channel register window.
- PRINT_ADDR, 32'h1000_0000: write-only debug print byte address.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid, mem_instr  in  1  picorv32 bus request; mem_instr is ignored.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  write strobes; 0 means read.
- mem_ready  out  1  registered one-cycle completion pulse; asserted for hits only.
- mem_rdata  out  32  registered read data; 0 when not completing a read hit.
- hit  out  1  combinational address match, used by the parent to mux ready/rdata against the BRAM.
- din  in  NUM_CH*DATA_WIDTH  RX words; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH]. The other per-channel buses use the same packing.
- val_in / ready_upward  in / out  NUM_CH  RX handshake.
- dout  out  NUM_CH*DATA_WIDTH  TX head words.
- val_out / ready_downward  out / in  NUM_CH  TX handshake.
- print_valid  out  1  one-cycle pulse.
- print_data  out  8  byte written to PRINT_ADDR.

## Operation
- hit = mem_valid && ((mem_addr & ~32'hFFF) == BASE_ADDR || mem_addr == PRINT_ADDR).
- Channel decode: ch = mem_addr[7:4], reg = mem_addr[3:2].
  - reg 0, write: push TX[ch].
  - reg 1, read: pop RX[ch].
  - reg 2, read: STATUS = {8'b0, tx_count[7:0], rx_count[7:0], 6'b0, tx_notfull, rx_nonempty}.
  - reg 3, write with wdata[0]=1: flush both FIFOs of ch. Reg 3 reads as 0.
  - Writes to read-only registers are dropped but still complete. Reads of reg 0 return 0.
- Channels ch >= NUM_CH: read 0, writes dropped, completion proceeds normally.
- Blocking access: a TX push to a full FIFO, or an RX pop from an empty FIFO, stalls. mem_ready stays 0 until space or data appears, then completes.
- Bus FSM states:
  - IDLE: on a hit whose condition is met, go to DONE.
  - DONE: mem_ready=1 for one cycle, then go to GAP.
  - GAP: ignore mem_valid for one cycle, then return to IDLE.
  - The push, pop, or flush takes effect on the same edge that enters DONE. mem_rdata is loaded on that edge.
- Print: a write hit to PRINT_ADDR completes like any other write and pulses print_valid with print_data = mem_wdata[7:0] in the DONE cycle.
- FIFO contents are first-word-fall-through:
  - val_out[i] = !tx_empty[i]; dout shows the head.
  - Pop on val_out && ready_downward.
  - ready_upward[i] = !rx_full[i]; push on val_in && ready_upward.
- Counts are $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: all FIFOs empty, all counts 0, FSM in IDLE. Outputs: mem_ready=0, mem_rdata=0, print_valid=0, print_data=0, val_out=0, ready_upward=all 1s.
- Latency, non-stalled access: mem_valid sampled at edge N, mem_ready high in cycle N+1. Minimum two cycles per bus transaction.
- A stream word pushed into RX at edge N is poppable by a CPU access sampled at edge N+1.
- A CPU TX push at edge N gives val_out=1 in cycle N+1.
- A full FIFO never accepts a push, even with a simultaneous pop. A simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- A flush coincident with a stream-side push or pop wins: the count becomes 0.
- Reset asserted mid-transaction aborts it with no mem_ready pulse. FIFO contents are lost.

## Test plan
- Reset, then write 0xDEADBEEF to BASE+0x00 → val_out[0]=1 and dout[31:0]=0xDEADBEEF one cycle after mem_ready. With ready_downward[0]=1, val_out[0] drops the next cycle.
- With NUM_CH=5, FIFO_DEPTH=4: push 4 words on channel 2 RX with the CPU idle → ready_upward[2]=0. STATUS at BASE+0x28 reads rx_count=4, rx_nonempty=1. Four pops at BASE+0x24 return the words in order.
- Read BASE+0x14 while RX[1] is empty → mem_ready held 0 for 10 cycles. Drive val_in[1]=1, din=0x55 → mem_ready pulses the following cycle with rdata=0x55.
- Push 4 TX words on channel 4 with ready_downward=0 and issue a 5th write → it stalls. Flush via BASE+0x4C from a second master model, or release ready_downward for one cycle → the 5th write completes. Count checked to be 4.
- Write 0x41 to PRINT_ADDR → print_valid pulses one cycle with print_data=0x41; no FIFO changes.
- Read BASE+0x94 (channel 9, NUM_CH=5) → completes in 2 cycles with rdata=0. Assert resetn=0 during a stalled pop → no mem_ready, all outputs at reset values.

Source files
------------

// File: rtl/riscv_stream_mmio.sv
// Memory-mapped stream I/O slave for the picorv32 native bus: NUM_CH channels,
// each with a TX and RX first-word-fall-through FIFO, plus a debug print byte port.
module riscv_stream_mmio #(
  parameter int          NUM_CH     = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [31:0] PRINT_ADDR = 32'h1000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         mem_valid,
  input  logic                         mem_instr,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [31:0]                  mem_rdata,
  output logic                         hit,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]            val_in,
  output logic [NUM_CH-1:0]            ready_upward,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]            val_out,
  input  logic [NUM_CH-1:0]            ready_downward,
  output logic                         print_valid,
  output logic [7:0]                   print_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mem_ready_q, print_valid_q, print_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  print_data_q, print_data_d;

  logic        in_win_s, is_print_s, is_wr_s, ch_ok_s;
  logic        push_req_s, pop_req_s, flush_req_s, cond_s, go_s;
  logic [3:0]  ch_s;
  logic [1:0]  reg_s;
  logic        unused_s;

  logic [NUM_CH-1:0]     cpu_push_s, cpu_pop_s, cpu_flush_s, tx_full_s, rx_empty_s;
  logic [DATA_WIDTH-1:0] rx_head_s [NUM_CH];
  logic [CW-1:0]         tx_cnt_s  [NUM_CH];
  logic [CW-1:0]         rx_cnt_s  [NUM_CH];

  logic                  sel_tx_full_s, sel_rx_empty_s;
  logic [DATA_WIDTH-1:0] sel_head_s;
  logic [CW-1:0]         sel_tx_cnt_s, sel_rx_cnt_s;

  assign unused_s   = ^{mem_instr, mem_wdata};
  assign is_print_s = (mem_addr == PRINT_ADDR);
  assign in_win_s   = ((mem_addr & ~32'h0000_0FFF) == BASE_ADDR);
  assign hit        = mem_valid && (in_win_s || is_print_s);
  assign ch_s       = mem_addr[7:4];
  assign reg_s      = mem_addr[3:2];
  assign is_wr_s    = (mem_wstrb != 4'h0);
  assign ch_ok_s    = in_win_s && !is_print_s && ({28'h0, ch_s} < 32'(NUM_CH));

  assign push_req_s  = ch_ok_s && (reg_s == 2'd0) && is_wr_s;
  assign pop_req_s   = ch_ok_s && (reg_s == 2'd1) && !is_wr_s;
  assign flush_req_s = ch_ok_s && (reg_s == 2'd3) && is_wr_s && mem_wdata[0];

  // Per-channel state of the addressed channel
  always_comb begin
    sel_tx_full_s  = 1'b0;
    sel_rx_empty_s = 1'b1;
    sel_head_s     = {DATA_WIDTH{1'b0}};
    sel_tx_cnt_s   = {CW{1'b0}};
    sel_rx_cnt_s   = {CW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_s == 4'(i)) begin
        sel_tx_full_s  = tx_full_s[i];
        sel_rx_empty_s = rx_empty_s[i];
        sel_head_s     = rx_head_s[i];
        sel_tx_cnt_s   = tx_cnt_s[i];
        sel_rx_cnt_s   = rx_cnt_s[i];
      end else begin
        sel_tx_full_s  = sel_tx_full_s;
      end
    end
  end

  // Blocking accesses wait in IDLE until their FIFO can serve them
  assign cond_s = !(push_req_s && sel_tx_full_s) && !(pop_req_s && sel_rx_empty_s);
  assign go_s   = (state_q == ST_IDLE) && hit && cond_s;

  always_comb begin
    cpu_push_s  = {NUM_CH{1'b0}};
    cpu_pop_s   = {NUM_CH{1'b0}};
    cpu_flush_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (go_s && (ch_s == 4'(i))) begin
        cpu_push_s[i]  = push_req_s;
        cpu_pop_s[i]   = pop_req_s;
        cpu_flush_s[i] = flush_req_s;
      end else begin
        cpu_push_s[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    rdata_d = 32'h0000_0000;
    if (go_s && !is_wr_s && ch_ok_s) begin
      case (reg_s)
        2'd1:    rdata_d = 32'(sel_head_s);
        2'd2:    rdata_d = {8'h00, 8'(sel_tx_cnt_s), 8'(sel_rx_cnt_s), 6'h00,
                            !sel_tx_full_s, !sel_rx_empty_s};
        default: rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  always_comb begin
    print_valid_d = go_s && is_print_s && is_wr_s;
    if (print_valid_d) begin
      print_data_d = mem_wdata[7:0];
    end else begin
      print_data_d = print_data_q;
    end
  end

  // Bus handshake: IDLE -> DONE (ready pulse) -> GAP (ignore mem_valid) -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = go_s ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      mem_ready_q   <= 1'b0;
      rdata_q       <= 32'h0000_0000;
      print_valid_q <= 1'b0;
      print_data_q  <= 8'h00;
    end else begin
      state_q       <= state_d;
      mem_ready_q   <= go_s;
      rdata_q       <= rdata_d;
      print_valid_q <= print_valid_d;
      print_data_q  <= print_data_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = rdata_q;
  assign print_valid = print_valid_q;
  assign print_data  = print_data_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]         tx_cnt_q, rx_cnt_q;
    logic                  tx_pop_s, rx_push_s;

    assign tx_full_s[g]    = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign val_out[g]      = (tx_cnt_q != {CW{1'b0}});
    assign dout[g*DATA_WIDTH +: DATA_WIDTH] = tx_mem_q[tx_rp_q];
    assign tx_pop_s        = val_out[g] && ready_downward[g];

    assign rx_empty_s[g]   = (rx_cnt_q == {CW{1'b0}});
    assign ready_upward[g] = (rx_cnt_q != CW'(FIFO_DEPTH));
    assign rx_push_s       = val_in[g] && ready_upward[g];

    assign rx_head_s[g] = rx_mem_q[rx_rp_q];
    assign tx_cnt_s[g]  = tx_cnt_q;
    assign rx_cnt_s[g]  = rx_cnt_q;

    // Storage carries no reset; occupancy is tracked by the counters alone
    always_ff @(posedge clk) begin
      if (cpu_push_s[g]) tx_mem_q[tx_wp_q] <= mem_wdata[DATA_WIDTH-1:0];
      if (rx_push_s)     rx_mem_q[rx_wp_q] <= din[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Flush overrides any coincident stream-side transfer
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        tx_wp_q  <= {AW{1'b0}};
        tx_rp_q  <= {AW{1'b0}};
        tx_cnt_q <= {CW{1'b0}};
      end else if (cpu_flush_s[g]) begin
        tx_wp_q  <= {AW{1'b0}};
        tx_rp_q  <= {AW{1'b0}};
        tx_cnt_q <= {CW{1'b0}};
      end else begin
        if (cpu_push_s[g]) tx_wp_q <= tx_wp_q + AW'(1);
        if (tx_pop_s)      tx_rp_q <= tx_rp_q + AW'(1);
        case ({cpu_push_s[g], tx_pop_s})
          2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
          2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
          default: tx_cnt_q <= tx_cnt_q;
        endcase
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rx_wp_q  <= {AW{1'b0}};
        rx_rp_q  <= {AW{1'b0}};
        rx_cnt_q <= {CW{1'b0}};
      end else if (cpu_flush_s[g]) begin
        rx_wp_q  <= {AW{1'b0}};
        rx_rp_q  <= {AW{1'b0}};
        rx_cnt_q <= {CW{1'b0}};
      end else begin
        if (rx_push_s)    rx_wp_q <= rx_wp_q + AW'(1);
        if (cpu_pop_s[g]) rx_rp_q <= rx_rp_q + AW'(1);
        case ({rx_push_s, cpu_pop_s[g]})
          2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
          2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
          default: rx_cnt_q <= rx_cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_stream_mmio.sv
// Randomized self-checking bench for riscv_stream_mmio against a queue-based model.
module tb_riscv_stream_mmio;

  localparam int          NCH   = 5;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] PADDR = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0]       mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [3:0]        mem_wstrb = 4'h0;
  logic              mem_ready, hit, print_valid;
  logic [31:0]       mem_rdata;
  logic [7:0]        print_data;
  logic [NCH*DW-1:0] din = '0, dout;
  logic [NCH-1:0]    val_in = '0, ready_upward, val_out, ready_downward = '0;

  riscv_stream_mmio #(.NUM_CH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                      .BASE_ADDR(BASE), .PRINT_ADDR(PADDR)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .hit(hit),
    .din(din), .val_in(val_in), .ready_upward(ready_upward),
    .dout(dout), .val_out(val_out), .ready_downward(ready_downward),
    .print_valid(print_valid), .print_data(print_data));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain queues per FIFO, the last printed byte, the pending request
  logic [31:0] txq [NCH][$];
  logic [31:0] rxq [NCH][$];
  logic [7:0]  exp_pdata = 8'h00;
  logic        req_active = 1'b0, fired = 1'b0, rand_stream = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  int          wait_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_of(input int c);
    return {8'h00, 8'(txq[c].size()), 8'(rxq[c].size()), 6'h00,
            (txq[c].size() < DEPTH), (rxq[c].size() != 0)};
  endfunction

  task automatic check_reset_outputs();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_pvalid", 32'(print_valid), 32'd0);
    check("rst_pdata", 32'(print_data), 32'd0);
    check("rst_val_out", 32'(val_out), 32'd0);
    check("rst_ready_up", 32'(ready_upward), 32'h1F);
  endtask

  // One clock: check stream-side outputs, predict this edge, advance model, check bus outputs
  task automatic tick();
    logic [NCH-1:0] exp_vout, exp_rup, tx_pop, rx_push;
    logic           fire, is_wr, in_win, is_pr, ch_ok;
    int             ch, rg;
    logic [31:0]    erd;
    if (rand_stream) begin
      val_in         = NCH'($urandom);
      ready_downward = NCH'($urandom);
      for (int i = 0; i < NCH; i++) din[i*DW +: DW] = $urandom;
    end
    mem_valid = req_active && !fired;
    #0;
    for (int i = 0; i < NCH; i++) begin
      exp_vout[i] = (txq[i].size() != 0);
      exp_rup[i]  = (rxq[i].size() < DEPTH);
      if (exp_vout[i]) check("dout", dout[i*DW +: DW], txq[i][0]);
    end
    check("val_out", 32'(val_out), 32'(exp_vout));
    check("ready_up", 32'(ready_upward), 32'(exp_rup));
    in_win = ((mem_addr & ~32'h0000_0FFF) == BASE);
    is_pr  = (mem_addr == PADDR);
    check("hit", 32'(hit), 32'(mem_valid && (in_win || is_pr)));
    is_wr = (mem_wstrb != 4'h0);
    ch    = int'(mem_addr[7:4]);
    rg    = int'(mem_addr[3:2]);
    ch_ok = in_win && !is_pr && (ch < NCH);
    fire  = 1'b0;
    erd   = 32'h0;
    if (mem_valid && (in_win || is_pr)) begin
      fire = 1'b1;
      if (ch_ok && rg == 0 && is_wr && txq[ch].size() == DEPTH) fire = 1'b0;
      if (ch_ok && rg == 1 && !is_wr && rxq[ch].size() == 0) fire = 1'b0;
      if (fire && ch_ok && !is_wr && rg == 1) erd = rxq[ch][0];
      if (fire && ch_ok && !is_wr && rg == 2) erd = status_of(ch);
    end
    for (int i = 0; i < NCH; i++) begin
      tx_pop[i]  = ready_downward[i] && exp_vout[i];
      rx_push[i] = val_in[i] && exp_rup[i];
    end
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (tx_pop[i])  void'(txq[i].pop_front());
      if (rx_push[i]) rxq[i].push_back(din[i*DW +: DW]);
    end
    if (fire) begin
      if (is_pr && is_wr) exp_pdata = mem_wdata[7:0];
      if (ch_ok && is_wr && rg == 0) txq[ch].push_back(mem_wdata);
      if (ch_ok && !is_wr && rg == 1) void'(rxq[ch].pop_front());
      if (ch_ok && is_wr && rg == 3 && mem_wdata[0]) begin
        txq[ch].delete();
        rxq[ch].delete();
      end
    end
    #1;
    check("mem_ready", 32'(mem_ready), 32'(fire));
    check("mem_rdata", mem_rdata, erd);
    check("print_valid", 32'(print_valid), 32'(fire && is_pr && is_wr));
    check("print_data", 32'(print_data), 32'(exp_pdata));
    if (fire) begin
      fired      = 1'b1;
      last_rdata = mem_rdata;
    end
  endtask

  task automatic bus_start(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    mem_addr    = a;
    mem_wdata   = wd;
    mem_wstrb   = ws;
    req_active  = 1'b1;
    fired       = 1'b0;
    wait_cycles = 0;
  endtask

  // Two idle cycles after completion keep every new request landing in IDLE
  task automatic bus_wait(input int budget);
    while (!fired && wait_cycles < budget) begin
      tick();
      wait_cycles++;
    end
    check("bus_done", 32'(fired), 32'd1);
    req_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    bus_start(a, wd, ws);
    bus_wait(200);
    rd = last_rdata;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] words [4];
    int          c;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    resetn = 1'b1;
    tick();

    // TX push becomes visible one cycle after the ready pulse, and drains on ready
    bus(BASE + 32'h00, 32'hDEAD_BEEF, 4'hF, rd);
    check("t1_vout", 32'(val_out[0]), 32'd1);
    check("t1_dout", dout[31:0], 32'hDEAD_BEEF);
    ready_downward[0] = 1'b1;
    tick();
    ready_downward[0] = 1'b0;
    check("t1_drain", 32'(val_out[0]), 32'd0);

    // Fill RX[2] from the stream side, then status and ordered pops
    for (int k = 0; k < 4; k++) begin
      words[k]       = $urandom;
      val_in[2]      = 1'b1;
      din[64 +: 32]  = words[k];
      tick();
    end
    val_in[2] = 1'b0;
    tick();
    check("t2_rup", 32'(ready_upward[2]), 32'd0);
    bus(BASE + 32'h28, 32'h0, 4'h0, rd);
    check("t2_status", rd, 32'h0000_0403);
    for (int k = 0; k < 4; k++) begin
      bus(BASE + 32'h24, 32'h0, 4'h0, rd);
      check("t2_pop", rd, words[k]);
    end

    // Pop from empty RX[1] stalls until a stream word arrives
    bus_start(BASE + 32'h14, 32'h0, 4'h0);
    repeat (10) tick();
    check("t3_stall", 32'(fired), 32'd0);
    val_in[1]     = 1'b1;
    din[32 +: 32] = 32'h0000_0055;
    tick();
    val_in[1] = 1'b0;
    bus_wait(1);
    check("t3_rdata", last_rdata, 32'h0000_0055);

    // Fifth push to a full TX[4] stalls until one word drains
    for (int k = 0; k < 4; k++) bus(BASE + 32'h40, 32'h400 + 32'(k), 4'hF, rd);
    bus_start(BASE + 32'h40, 32'h404, 4'hF);
    repeat (5) tick();
    check("t4_stall", 32'(fired), 32'd0);
    ready_downward[4] = 1'b1;
    tick();
    ready_downward[4] = 1'b0;
    bus_wait(2);
    bus(BASE + 32'h48, 32'h0, 4'h0, rd);
    check("t4_count", rd, 32'h0004_0000);
    bus(BASE + 32'h4C, 32'h0, 4'hF, rd);
    bus(BASE + 32'h48, 32'h0, 4'h0, rd);
    check("t4_noflush", rd, 32'h0004_0000);
    bus(BASE + 32'h4C, 32'h1, 4'hF, rd);
    bus(BASE + 32'h48, 32'h0, 4'h0, rd);
    check("t4_flush", rd, 32'h0000_0002);

    // Debug print
    bus(PADDR, 32'h0000_0041, 4'h1, rd);
    check("t5_pdata", 32'(print_data), 32'h41);
    bus(BASE + 32'h48, 32'h0, 4'h0, rd);
    check("t5_nofifo", rd, 32'h0000_0002);

    // Unimplemented channel completes at once
    bus_start(BASE + 32'h94, 32'h0, 4'h0);
    bus_wait(1);
    check("t6_rdata", last_rdata, 32'h0);
    bus_start(BASE + 32'h90, 32'h1234, 4'hF);
    bus_wait(1);

    // Random bus traffic against random stream activity
    rand_stream = 1'b1;
    repeat (300) begin
      c = $urandom_range(0, 6);
      if (c == 6) c = 9;
      rd = BASE + 32'(c * 16) + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 15) == 0) rd = PADDR;
      if ($urandom_range(0, 1) == 1) bus_start(rd, $urandom, 4'($urandom_range(1, 15)));
      else                           bus_start(rd, $urandom, 4'h0);
      bus_wait(200);
    end
    rand_stream    = 1'b0;
    val_in         = '0;
    ready_downward = '0;
    tick();

    // Reset during a stalled pop aborts it
    bus(BASE + 32'h3C, 32'h1, 4'hF, rd);
    bus_start(BASE + 32'h34, 32'h0, 4'h0);
    repeat (3) tick();
    check("t7_stall", 32'(fired), 32'd0);
    resetn     = 1'b0;
    req_active = 1'b0;
    mem_valid  = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < NCH; i++) begin
      txq[i].delete();
      rxq[i].delete();
    end
    exp_pdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    resetn = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
